gray_code_converter_pipe: RTL and testbench

//  Parametrised, pipelined Gray<->binary converter with valid/ready handshake on both sides.

---
 rtl/gray_pkg.sv | 44 ++++
 rtl/gray_pipe_stage.sv | 62 ++++++
 rtl/gray_code_converter_pipe.sv | 126 ++++++++++++
 tb/tb_gray_code_converter_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//   Shared types and helpers for the Gray<->binary converter pipeline.
//   - mode_e   : per-word conversion direction carried through the pipe
//   - gray2bin : Gray -> binary, width-generic (operates on MAX_W bits;
//                narrower callers zero-extend in and truncate out)
//   - bin2gray : binary -> Gray, width-generic in the same way
//   - popcount : number of set bits in a MAX_W-bit vector
// ---------------------------------------------------------------------------
package gray_pkg;

  typedef enum logic {
    MODE_G2B = 1'b0,
    MODE_B2G = 1'b1
  } mode_e;

  localparam int MAX_W = 64;

  // Zero-extended upper bits contribute nothing to the prefix XOR, so an
  // N-bit value converted at MAX_W and truncated back to N bits is exact.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int popcount(input logic [MAX_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// ---------------------------------------------------------------------------
// gray_pipe_stage
//   One elastic register slice holding {valid, mode, data}.
//   Ports:
//     clk, rstn              clock, asynchronous active-low reset
//     in_valid/in_ready      upstream handshake (in_ready is combinational
//                            from out_ready)
//     in_mode, in_data       word entering the slice
//     out_valid/out_ready    downstream handshake
//     out_mode, out_data     registered word leaving the slice
//   Parameter W: data width.
// ---------------------------------------------------------------------------
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  mode_e        in_mode,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output mode_e        out_mode,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  mode_e        mode_q, mode_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    // The slice can take a word when it is empty or its word leaves now.
    in_ready = !valid_q || out_ready;
    load     = in_ready && in_valid;
    valid_d  = in_ready ? in_valid : valid_q;
    // Payload only changes on a real load, so a stalled or drained slice
    // keeps its last value.
    mode_d   = load ? in_mode : mode_q;
    data_d   = load ? in_data : data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_G2B;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gray_code_converter_pipe.sv
// ---------------------------------------------------------------------------
// gray_code_converter_pipe
//   Pipelined Gray<->binary converter with valid/ready on both sides.
//   The conversion is combinational into the first register slice; the
//   remaining PIPE_DEPTH-1 slices only carry the word. Backpressure ripples
//   combinationally from out_ready back to in_ready.
//   Parameters:
//     N           data width (2..64)
//     PIPE_DEPTH  register slices between acceptance and output (1..4)
//   Ports:
//     clk, rstn             clock, asynchronous active-low reset
//     in_valid/in_ready     input handshake
//     in_mode               MODE_G2B (Gray->binary) or MODE_B2G
//     in_data               value to convert
//     out_valid/out_ready   output handshake
//     out_mode, out_data    mode and converted value
//     err_adj, err_clr      sticky Gray adjacency error and its clear
//                           (present only when GRAY_ADJ_CHECK_EN is defined)
//   Build option: GRAY_ADJ_CHECK_EN enables the adjacency checker.
// ---------------------------------------------------------------------------
module gray_code_converter_pipe
  import gray_pkg::*;
#(
  parameter int N          = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  mode_e        in_mode,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output mode_e        out_mode,
  output logic [N-1:0] out_data
`ifdef GRAY_ADJ_CHECK_EN
  ,
  output logic         err_adj,
  input  logic         err_clr
`endif
);

  // Chain index 0 is the input side, index PIPE_DEPTH the output side.
  logic         valid_c [PIPE_DEPTH+1];
  logic         ready_c [PIPE_DEPTH+1];
  mode_e        mode_c  [PIPE_DEPTH+1];
  logic [N-1:0] data_c  [PIPE_DEPTH+1];
  logic [N-1:0] conv_data;

  always_comb begin
    if (in_mode == MODE_B2G) begin
      conv_data = N'(bin2gray(MAX_W'(in_data)));
    end else begin
      conv_data = N'(gray2bin(MAX_W'(in_data)));
    end
  end

  assign valid_c[0]          = in_valid;
  assign mode_c[0]           = in_mode;
  assign data_c[0]           = conv_data;
  assign in_ready            = ready_c[0];
  assign ready_c[PIPE_DEPTH] = out_ready;
  assign out_valid           = valid_c[PIPE_DEPTH];
  assign out_mode            = mode_c[PIPE_DEPTH];
  assign out_data            = data_c[PIPE_DEPTH];

  generate
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      gray_pipe_stage #(
        .W(N)
      ) u_stage (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (valid_c[gi]),
        .in_ready (ready_c[gi]),
        .in_mode  (mode_c[gi]),
        .in_data  (data_c[gi]),
        .out_valid(valid_c[gi+1]),
        .out_ready(ready_c[gi+1]),
        .out_mode (mode_c[gi+1]),
        .out_data (data_c[gi+1])
      );
    end
  endgenerate

`ifdef GRAY_ADJ_CHECK_EN
  logic [N-1:0] prev_gray_q, prev_gray_d;
  logic         prev_seen_q, prev_seen_d;
  logic         err_adj_q, err_adj_d;
  logic         g2b_accept;
  logic         adj_viol;

  always_comb begin
    // Only accepted Gray-coded (mode 0) words form the tracked sequence.
    g2b_accept  = in_valid && in_ready && (in_mode == MODE_G2B);
    adj_viol    = g2b_accept && prev_seen_q &&
                  (popcount(MAX_W'(in_data ^ prev_gray_q)) != 1);
    prev_gray_d = g2b_accept ? in_data : prev_gray_q;
    prev_seen_d = prev_seen_q || g2b_accept;
    // A fresh violation beats a simultaneous clear.
    if (adj_viol) begin
      err_adj_d = 1'b1;
    end else if (err_clr) begin
      err_adj_d = 1'b0;
    end else begin
      err_adj_d = err_adj_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_gray_q <= '0;
      prev_seen_q <= 1'b0;
      err_adj_q   <= 1'b0;
    end else begin
      prev_gray_q <= prev_gray_d;
      prev_seen_q <= prev_seen_d;
      err_adj_q   <= err_adj_d;
    end
  end

  assign err_adj = err_adj_q;
`endif

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// ---------------------------------------------------------------------------
// tb_gray_code_converter_pipe
//   Two instances share clock and reset: A (N=4, PIPE_DEPTH=2) for directed
//   cases and the optional adjacency checker, B (N=16, PIPE_DEPTH=4) for
//   stall and random valid/ready traffic. Expected words come from lookup
//   tables built by inverting the binary->Gray map.
// ---------------------------------------------------------------------------
module tb_gray_code_converter_pipe;
  import gray_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance A
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  mode_e       a_in_mode, a_out_mode;
  logic [3:0]  a_in_data, a_out_data;
`ifdef GRAY_ADJ_CHECK_EN
  logic        a_err_adj, a_err_clr;
`endif
  // Instance B
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  mode_e       b_in_mode, b_out_mode;
  logic [15:0] b_in_data, b_out_data;
`ifdef GRAY_ADJ_CHECK_EN
  logic        b_err_adj, b_err_clr;
`endif

  gray_code_converter_pipe #(.N(4), .PIPE_DEPTH(2)) u_dut_a (
    .clk(clk), .rstn(rstn),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode), .out_data(a_out_data)
`ifdef GRAY_ADJ_CHECK_EN
    , .err_adj(a_err_adj), .err_clr(a_err_clr)
`endif
  );

  gray_code_converter_pipe #(.N(16), .PIPE_DEPTH(4)) u_dut_b (
    .clk(clk), .rstn(rstn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode), .out_data(b_out_data)
`ifdef GRAY_ADJ_CHECK_EN
    , .err_adj(b_err_adj), .err_clr(b_err_clr)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0]  inv4 [16];
  logic [15:0] inv16 [65536];

  logic [4:0]  a_exp_q [$];
  int          a_lat_q [$];
  logic [16:0] b_exp_q [$];
  int          b_lat_q [$];
  bit          a_lat_chk = 1'b0;
  bit          b_lat_chk = 1'b0;
  int          a_acc_cnt = 0;
  int          b_acc_cnt = 0;
  int          b_dlv_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref4(input logic m, input logic [3:0] d);
    return m ? (d ^ (d >> 1)) : inv4[d];
  endfunction

  function automatic logic [15:0] ref16(input logic m, input logic [15:0] d);
    return m ? (d ^ (d >> 1)) : inv16[d];
  endfunction

  // One clock cycle on A: drive, observe at negedge, then advance.
  task automatic step_a(input logic v, input logic m, input logic [3:0] d, input logic r);
    logic [4:0] e;
    int lat;
    a_in_valid = v; a_in_mode = mode_e'(m); a_in_data = d; a_out_ready = r;
    @(negedge clk);
    if (a_out_valid && a_out_ready) begin
      chk("a_word_pending", 64'(a_exp_q.size() != 0), 64'(1));
      if (a_exp_q.size() != 0) begin
        e = a_exp_q.pop_front();
        lat = a_lat_q.pop_front();
        $display("A out: mode=%0d data=%h expected mode=%0d data=%h", a_out_mode, a_out_data, e[4], e[3:0]);
        chk("a_data", 64'(a_out_data), 64'(e[3:0]));
        chk("a_mode", 64'(a_out_mode), 64'(e[4]));
        if (a_lat_chk) chk("a_latency", 64'(cyc - lat), 64'(2));
      end
    end
    if (a_in_valid && a_in_ready) begin
      a_exp_q.push_back({m, ref4(m, d)});
      a_lat_q.push_back(cyc);
      a_acc_cnt++;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic step_b(input logic v, input logic m, input logic [15:0] d, input logic r);
    logic [16:0] e;
    int lat;
    b_in_valid = v; b_in_mode = mode_e'(m); b_in_data = d; b_out_ready = r;
    @(negedge clk);
    if (b_out_valid && b_out_ready) begin
      b_dlv_cnt++;
      chk("b_word_pending", 64'(b_exp_q.size() != 0), 64'(1));
      if (b_exp_q.size() != 0) begin
        e = b_exp_q.pop_front();
        lat = b_lat_q.pop_front();
        if (b_lat_chk)
          $display("B out: mode=%0d data=%h expected data=%h", b_out_mode, b_out_data, e[15:0]);
        chk("b_data", 64'(b_out_data), 64'(e[15:0]));
        chk("b_mode", 64'(b_out_mode), 64'(e[16]));
        if (b_lat_chk) chk("b_latency", 64'(cyc - lat), 64'(4));
      end
    end
    if (b_in_valid && b_in_ready) begin
      b_exp_q.push_back({m, ref16(m, d)});
      b_lat_q.push_back(cyc);
      b_acc_cnt++;
    end
    @(posedge clk); #1; cyc++;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && a_exp_q.size() != 0; i++) step_a(1'b0, 1'b0, 4'h0, 1'b1);
    chk("a_drained", 64'(a_exp_q.size()), 64'(0));
  endtask

  task automatic drain_b();
    for (int i = 0; i < 80 && b_exp_q.size() != 0; i++) step_b(1'b0, 1'b0, 16'h0, 1'b1);
    chk("b_drained", 64'(b_exp_q.size()), 64'(0));
  endtask

  initial begin
    int acc0;
    logic [3:0] hold;
    bit have_hold;

    // Reference tables: invert g = b ^ (b >> 1) over the whole code space.
    for (int b = 0; b < 16; b++) inv4[4'(b) ^ (4'(b) >> 1)] = 4'(b);
    for (int b = 0; b < 65536; b++) inv16[16'(b) ^ (16'(b) >> 1)] = 16'(b);

    rstn = 1'b0;
    a_in_valid = 1'b0; a_in_mode = MODE_G2B; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_mode = MODE_G2B; b_in_data = '0; b_out_ready = 1'b0;
`ifdef GRAY_ADJ_CHECK_EN
    a_err_clr = 1'b0; b_err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    chk("rst_a_out_data",  64'(a_out_data),  64'(0));
    chk("rst_a_out_mode",  64'(a_out_mode),  64'(0));
    chk("rst_a_in_ready",  64'(a_in_ready),  64'(1));
    chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
    chk("rst_b_in_ready",  64'(b_in_ready),  64'(1));
`ifdef GRAY_ADJ_CHECK_EN
    chk("rst_a_err_adj",   64'(a_err_adj),   64'(0));
`endif
    rstn = 1'b1;
    @(posedge clk); #1;

    // Test 1: Gray 1101 -> binary 1001, exactly 2 cycles after accept.
    a_lat_chk = 1'b1;
    step_a(1'b1, 1'b0, 4'b1101, 1'b1);
    chk("t1_not_early", 64'(a_out_valid), 64'(0));
    step_a(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t1_valid", 64'(a_out_valid), 64'(1));
    chk("t1_data",  64'(a_out_data), 64'(4'b1001));
    chk("t1_mode",  64'(a_out_mode), 64'(0));
    drain_a();

    // Test 2: binary 1001 -> Gray 1101, then full sweep back-to-back.
    step_a(1'b1, 1'b1, 4'b1001, 1'b1);
    step_a(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t2_valid", 64'(a_out_valid), 64'(1));
    chk("t2_data",  64'(a_out_data), 64'(4'b1101));
    chk("t2_mode",  64'(a_out_mode), 64'(1));
    drain_a();
    acc0 = a_acc_cnt;
    for (int m = 0; m < 2; m++)
      for (int v = 0; v < 16; v++) step_a(1'b1, 1'(m), 4'(v), 1'b1);
    chk("t2_sweep_accepts", 64'(a_acc_cnt - acc0), 64'(32));
    drain_a();
    a_lat_chk = 1'b0;

    // Test 3: six stalled cycles with input pressure.
    acc0 = a_acc_cnt;
    have_hold = 1'b0;
    hold = '0;
    for (int k = 0; k < 6; k++) begin
      step_a(1'b1, 1'b0, 4'(k + 3), 1'b0);
      if (a_out_valid) begin
        if (have_hold) chk("t3_hold", 64'(a_out_data), 64'(hold));
        else begin hold = a_out_data; have_hold = 1'b1; end
      end
    end
    chk("t3_accepts", 64'(a_acc_cnt - acc0), 64'(2));
    chk("t3_in_ready", 64'(a_in_ready), 64'(0));
    chk("t3_out_valid", 64'(a_out_valid), 64'(1));
    drain_a();

    // Test 4: asynchronous reset with two words in flight.
    step_a(1'b1, 1'b1, 4'h3, 1'b0);
    step_a(1'b1, 1'b1, 4'h5, 1'b0);
    chk("t4_full", 64'(a_out_valid), 64'(1));
    a_in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("t4_async_out_valid", 64'(a_out_valid), 64'(0));
    chk("t4_rst_in_ready", 64'(a_in_ready), 64'(1));
    a_exp_q.delete();
    a_lat_q.delete();
    @(posedge clk); #1;
    chk("t4_held_out_valid", 64'(a_out_valid), 64'(0));
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) step_a(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t4_release_in_ready", 64'(a_in_ready), 64'(1));
    step_a(1'b1, 1'b1, 4'h7, 1'b1);
    drain_a();

`ifdef GRAY_ADJ_CHECK_EN
    // Test 5: adjacency checker.
    a_err_clr = 1'b0;
    step_a(1'b1, 1'b0, 4'b0000, 1'b1);
    chk("t5_err_w1", 64'(a_err_adj), 64'(0));
    step_a(1'b1, 1'b0, 4'b0001, 1'b1);
    chk("t5_err_w2", 64'(a_err_adj), 64'(0));
    step_a(1'b1, 1'b0, 4'b0011, 1'b1);
    chk("t5_err_w3", 64'(a_err_adj), 64'(0));
    step_a(1'b1, 1'b0, 4'b0000, 1'b1);
    chk("t5_err_w4", 64'(a_err_adj), 64'(1));
    step_a(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t5_err_sticky", 64'(a_err_adj), 64'(1));
    a_err_clr = 1'b1;
    step_a(1'b1, 1'b0, 4'b0101, 1'b1);
    chk("t5_set_beats_clr", 64'(a_err_adj), 64'(1));
    step_a(1'b1, 1'b0, 4'b0100, 1'b1);
    chk("t5_clr", 64'(a_err_adj), 64'(0));
    a_err_clr = 1'b0;
    step_a(1'b1, 1'b1, 4'b1111, 1'b1);
    step_a(1'b1, 1'b0, 4'b0110, 1'b1);
    chk("t5_mode1_ignored", 64'(a_err_adj), 64'(0));
    drain_a();
`endif

    // Test 6: wide instance -- latency, stall, random traffic.
    b_lat_chk = 1'b1;
    step_b(1'b1, 1'b0, 16'h1234, 1'b1);
    for (int k = 0; k < 5; k++) step_b(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t6_lat_drained", 64'(b_exp_q.size()), 64'(0));
    b_lat_chk = 1'b0;
    acc0 = b_acc_cnt;
    for (int k = 0; k < 8; k++) step_b(1'b1, 1'(k), 16'(k * 4099), 1'b0);
    chk("t6_stall_accepts", 64'(b_acc_cnt - acc0), 64'(4));
    chk("t6_stall_in_ready", 64'(b_in_ready), 64'(0));
    drain_b();
    for (int i = 0; i < 40000 && b_acc_cnt < 3000; i++)
      step_b(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom),
             1'($urandom_range(0, 3) != 0));
    chk("t6_random_accepts", 64'(b_acc_cnt >= 3000), 64'(1));
    drain_b();
    chk("t6_no_loss", 64'(b_dlv_cnt), 64'(b_acc_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
